scroll_v_multi: RTL and testbench

Parametrised successor to the single-layer vertical scroll counter. Produces N_LAYERS parallax y-offsets that advance while the move button is held, with up/down direction, pause, true modulo wrap, and a BCD score. Score drives a level counter that shortens the step period (speed-up). Sits between the button synchroniser and the VGA sprite/obstacle renderers and score display.

---
 rtl/scroll_pkg.sv | 12 +
 rtl/bcd_counter.sv | 54 +++++
 rtl/scroll_v_multi.sv | 148 ++++++++++++++
 tb/tb_scroll_v_multi.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scroll_pkg.sv
// Shared constants and types for the multi-layer vertical scroll block.
package scroll_pkg;

  localparam int POS_W_DEF    = 10;
  localparam int SCREEN_H_DEF = 480;
  localparam int LEVEL_W      = 4;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

endpackage

// File: rtl/bcd_counter.sv
// Saturating packed-BCD up-counter. Holds at all nines; flags each real increment.
module bcd_counter
  import scroll_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  output logic [DIGITS*4-1:0]   value,
  output logic                  saturated,
  output logic                  incremented
);

  logic [DIGITS*4-1:0] next_value;

  // Ripple a decimal carry up from digit 0 and detect the all-nines ceiling.
  always_comb begin
    logic       carry;
    bcd_digit_t digit;
    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    next_value = value;
    saturated  = 1'b1;
    carry      = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      digit = value[i*4 +: 4];
      if (digit != BCD_NINE) saturated = 1'b0;
      if (carry) begin
        if (digit == BCD_NINE) begin
          next_value[i*4 +: 4] = '0;
        end else begin
          next_value[i*4 +: 4] = digit + 4'd1;
          carry                = 1'b0;
        end
      end
    end
  end

  // Register the count; the incremented flag is high for the cycle the new value appears.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      value       <= '0;
      incremented <= 1'b0;
    end else begin
      incremented <= 1'b0;
      if (inc && !saturated) begin
        value       <= next_value;
        incremented <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/scroll_v_multi.sv
// Multi-layer parallax vertical scroller with pause, modulo wrap, BCD score and speed levels.
module scroll_v_multi
  import scroll_pkg::*;
#(
  parameter int N_LAYERS     = 2,
  parameter int POS_W        = POS_W_DEF,
  parameter int SCREEN_H     = SCREEN_H_DEF,
  parameter int STEP         = 2,
  parameter int TICK_CYCLES  = 250000,
  parameter int LEVEL_DEC    = 25000,
  parameter int MIN_TICK     = 50000,
  parameter int SCORE_TICKS  = 100,
  parameter int SCORE_DIGITS = 3,
  parameter int LEVEL_SCORE  = 10,
  parameter int MAX_LEVEL    = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         move_btn,
  input  logic                         dir,
  input  logic                         pause,
  output logic [N_LAYERS*POS_W-1:0]    y_pos,
  output logic [SCORE_DIGITS*4-1:0]    score,
  output logic [LEVEL_W-1:0]           level,
  output logic                         tick,
  output logic                         score_pulse
);

  localparam int CTR_W = $clog2(TICK_CYCLES + 1);
  localparam int SCW   = $clog2(SCORE_TICKS + 1);
  localparam int PW    = $clog2(LEVEL_SCORE + 1);
  localparam int AW    = POS_W + 1;
  localparam logic [AW-1:0] SCR = AW'(SCREEN_H);

  logic             move_active;
  logic             run;
  logic [CTR_W-1:0] ctr;
  logic [CTR_W-1:0] period_m1;
  logic             tick_now;
  logic [SCW-1:0]   score_ctr;
  logic             score_inc;
  logic             score_sat;
  logic [PW-1:0]    points;

  assign run       = move_active & ~pause;
  assign tick_now  = run && (ctr >= period_m1);
  assign score_inc = tick_now && (score_ctr == SCW'(SCORE_TICKS - 1));

  // Step period shrinks with level down to a floor.
  always_comb begin
    int p;
    p = TICK_CYCLES - int'(level) * LEVEL_DEC;
    if (p < MIN_TICK) p = MIN_TICK;
    period_m1 = CTR_W'(p - 1);
  end

  // Register the button, run the step-period counter and emit the tick pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      move_active <= 1'b0;
      ctr         <= '0;
      tick        <= 1'b0;
    end else begin
      move_active <= move_btn;
      tick        <= 1'b0;
      if (!move_active) begin
        ctr <= '0;
      end else if (!pause) begin
        if (tick_now) begin
          ctr  <= '0;
          tick <= 1'b1;
        end else begin
          ctr <= ctr + CTR_W'(1);
        end
      end
    end
  end

  // Per-layer position registers; layer k moves STEP*(k+1) per tick and wraps modulo SCREEN_H.
  for (genvar k = 0; k < N_LAYERS; k++) begin : g_layer
    localparam logic [AW-1:0] AMT = AW'(STEP * (k + 1));

    logic [POS_W-1:0] pos_q;
    logic [AW-1:0]    cur;
    logic [AW-1:0]    fwd;
    logic [AW-1:0]    back;
    logic [AW-1:0]    nxt;

    assign cur  = {1'b0, pos_q};
    assign fwd  = cur + AMT;
    assign back = cur + SCR - AMT;

    // Select the wrapped or plain result for the sampled direction.
    always_comb begin
      nxt = fwd;
      if (!dir) begin
        if (fwd >= SCR) nxt = fwd - SCR;
      end else begin
        nxt = (cur < AMT) ? back : cur - AMT;
      end
    end

    // Update this layer on each tick.
    always_ff @(posedge clk) begin
      if (reset)         pos_q <= '0;
      else if (tick_now) pos_q <= POS_W'(nxt);
    end

    assign y_pos[k*POS_W +: POS_W] = pos_q;
  end

  // Count ticks toward the next score point; retained across release and pause.
  always_ff @(posedge clk) begin
    if (reset) begin
      score_ctr <= '0;
    end else if (tick_now) begin
      if (score_inc) score_ctr <= '0;
      else           score_ctr <= score_ctr + SCW'(1);
    end
  end

  // Every LEVEL_SCORE score points raise the level, saturating at MAX_LEVEL.
  always_ff @(posedge clk) begin
    if (reset) begin
      points <= '0;
      level  <= '0;
    end else if (score_inc && !score_sat) begin
      if (points == PW'(LEVEL_SCORE - 1)) begin
        points <= '0;
        if (level != LEVEL_W'(MAX_LEVEL)) level <= level + LEVEL_W'(1);
      end else begin
        points <= points + PW'(1);
      end
    end
  end

  bcd_counter #(
    .DIGITS (SCORE_DIGITS)
  ) u_score (
    .clk         (clk),
    .reset       (reset),
    .inc         (score_inc),
    .value       (score),
    .saturated   (score_sat),
    .incremented (score_pulse)
  );

endmodule

// File: tb/tb_scroll_v_multi.sv
// Scoreboard bench for scroll_v_multi using small, fast-running parameters.
module tb_scroll_v_multi;

  localparam int N_LAYERS     = 2;
  localparam int POS_W        = 10;
  localparam int SCREEN_H     = 20;
  localparam int STEP         = 2;
  localparam int TICK_CYCLES  = 8;
  localparam int LEVEL_DEC    = 2;
  localparam int MIN_TICK     = 4;
  localparam int SCORE_TICKS  = 3;
  localparam int SCORE_DIGITS = 3;
  localparam int LEVEL_SCORE  = 2;
  localparam int MAX_LEVEL    = 7;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       move_btn;
  logic                       dir;
  logic                       pause;
  logic [N_LAYERS*POS_W-1:0]  y_pos;
  logic [SCORE_DIGITS*4-1:0]  score;
  logic [3:0]                 level;
  logic                       tick;
  logic                       score_pulse;

  scroll_v_multi #(
    .N_LAYERS     (N_LAYERS),
    .POS_W        (POS_W),
    .SCREEN_H     (SCREEN_H),
    .STEP         (STEP),
    .TICK_CYCLES  (TICK_CYCLES),
    .LEVEL_DEC    (LEVEL_DEC),
    .MIN_TICK     (MIN_TICK),
    .SCORE_TICKS  (SCORE_TICKS),
    .SCORE_DIGITS (SCORE_DIGITS),
    .LEVEL_SCORE  (LEVEL_SCORE),
    .MAX_LEVEL    (MAX_LEVEL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .move_btn    (move_btn),
    .dir         (dir),
    .pause       (pause),
    .y_pos       (y_pos),
    .score       (score),
    .level       (level),
    .tick        (tick),
    .score_pulse (score_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] y;
    logic [11:0] score;
    logic [3:0]  level;
    logic        sp;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   tick_cnt  = 0;
  int   sp_cnt    = 0;

  // Reference model state
  int m_y[N_LAYERS];
  int m_sctr, m_score, m_pts, m_level;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int period_of(input int lvl);
    int p;
    p = TICK_CYCLES - lvl * LEVEL_DEC;
    return (p < MIN_TICK) ? MIN_TICK : p;
  endfunction

  function automatic logic [19:0] pack_y();
    return {10'(m_y[1]), 10'(m_y[0])};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_LAYERS; k++) m_y[k] = 0;
    m_sctr = 0; m_score = 0; m_pts = 0; m_level = 0;
    exp_q.delete();
  endtask

  // Advance the model by one tick and queue the expected DUT state.
  task automatic push_exp(input logic d);
    exp_t e;
    bit   sp;
    sp = 1'b0;
    for (int k = 0; k < N_LAYERS; k++) begin
      if (!d) m_y[k] = (m_y[k] + STEP * (k + 1)) % SCREEN_H;
      else    m_y[k] = (m_y[k] + SCREEN_H - STEP * (k + 1)) % SCREEN_H;
    end
    if (m_sctr == SCORE_TICKS - 1) begin
      m_sctr = 0;
      if (m_score < 999) begin
        m_score++;
        sp = 1'b1;
        m_pts++;
        if (m_pts == LEVEL_SCORE) begin
          m_pts = 0;
          if (m_level < MAX_LEVEL) m_level++;
        end
      end
    end else begin
      m_sctr++;
    end
    e.y = pack_y(); e.score = to_bcd(m_score); e.level = 4'(m_level); e.sp = sp;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every tick against the scoreboard, 1 ns after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (score_pulse === 1'b1) sp_cnt++;
    if (tick === 1'b1) begin
      tick_cnt++;
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_tick: y_pos=%h score=%h level=%0d, none expected", y_pos, score, level);
      end else begin
        e = exp_q.pop_front();
        if (y_pos !== e.y || score !== e.score || level !== e.level || score_pulse !== e.sp)
          $display("FAIL tick_update: got y_pos=%h score=%h level=%0d sp=%b, expected y_pos=%h score=%h level=%0d sp=%b",
                   y_pos, score, level, score_pulse, e.y, e.score, e.level, e.sp);
        else
          pass_cnt++;
      end
    end else if (score_pulse === 1'b1) begin
      total_cnt++;
      $display("FAIL stray_score_pulse: score_pulse=1 without tick, score=%h", score);
    end
  end

  // Wait (from a negedge) for the next tick; n = clock edges until it appeared.
  task automatic wait_tick(input int budget, output int n, output bit got);
    int start;
    start = tick_cnt;
    n = 0;
    while (tick_cnt == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    got = (tick_cnt != start);
  endtask

  task automatic step_tick(input logic d, input int exp_n, output bit ok, output int n);
    bit got;
    dir = d;
    push_exp(d);
    wait_tick(exp_n + 20, n, got);
    if (!got) exp_q.delete();
    ok = got && (n == exp_n);
  endtask

  task automatic run_ticks(input int count, input logic d, output int bad);
    bit ok;
    int n;
    bad = 0;
    for (int i = 0; i < count; i++) begin
      step_tick(d, period_of(m_level), ok, n);
      if (!ok) bad++;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    int t0;
    reset = 1'b1; move_btn = 1'b0; dir = 1'b0; pause = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    total_cnt++;
    if (y_pos !== '0) $display("FAIL reset_y_pos: got %h, expected 0", y_pos); else pass_cnt++;
    total_cnt++;
    if (score !== '0 || level !== '0) $display("FAIL reset_score_level: got score=%h level=%0d, expected 0/0", score, level);
    else pass_cnt++;
    total_cnt++;
    if (tick !== 1'b0 || score_pulse !== 1'b0) $display("FAIL reset_pulses: got tick=%b sp=%b, expected 0/0", tick, score_pulse);
    else pass_cnt++;
    // Reset must win over a held button.
    t0 = tick_cnt;
    move_btn = 1'b1;
    repeat (15) @(negedge clk);
    total_cnt++;
    if (tick_cnt != t0 || y_pos !== '0) $display("FAIL reset_dominates: got %0d ticks y_pos=%h, expected 0 ticks y_pos=0", tick_cnt - t0, y_pos);
    else pass_cnt++;
    move_btn = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_first_tick();
    bit ok;
    int n, bad;
    move_btn = 1'b1;
    step_tick(1'b0, 9, ok, n);
    total_cnt++;
    if (!ok) $display("FAIL first_tick_latency: got %0d cycles, expected 9", n); else pass_cnt++;
    total_cnt++;
    if (y_pos !== {10'd4, 10'd2}) $display("FAIL first_tick_y_pos: got %h, expected %h", y_pos, {10'd4, 10'd2});
    else pass_cnt++;
    run_ticks(2, 1'b0, bad);
    total_cnt++;
    if (bad != 0) $display("FAIL tick_period_8: got %0d bad intervals, expected 0", bad); else pass_cnt++;
    total_cnt++;
    if (score !== 12'h001) $display("FAIL score_after_3_ticks: got %h, expected 001", score); else pass_cnt++;
  endtask

  task automatic test_pause();
    logic [19:0] y_save;
    logic [11:0] s_save;
    int t0, n;
    bit ok;
    repeat (5) @(negedge clk);
    pause = 1'b1;
    y_save = y_pos; s_save = score; t0 = tick_cnt;
    repeat (20) @(negedge clk);
    total_cnt++;
    if (tick_cnt != t0 || y_pos !== y_save || score !== s_save)
      $display("FAIL pause_freeze: got ticks=%0d y_pos=%h score=%h, expected 0 ticks y_pos=%h score=%h",
               tick_cnt - t0, y_pos, score, y_save, s_save);
    else pass_cnt++;
    pause = 1'b0;
    step_tick(1'b0, 3, ok, n);
    total_cnt++;
    if (!ok) $display("FAIL pause_resume: got tick after %0d cycles, expected 3", n); else pass_cnt++;
  endtask

  task automatic test_release();
    int t0, n;
    bit ok;
    repeat (5) @(negedge clk);
    move_btn = 1'b0;
    t0 = tick_cnt;
    repeat (6) @(negedge clk);
    total_cnt++;
    if (tick_cnt != t0 || score !== 12'h001) $display("FAIL release_hold: got ticks=%0d score=%h, expected 0 ticks score=001", tick_cnt - t0, score);
    else pass_cnt++;
    move_btn = 1'b1;
    step_tick(1'b0, 1 + period_of(m_level), ok, n);
    total_cnt++;
    if (!ok) $display("FAIL release_ctr_cleared: got tick after %0d cycles, expected %0d", n, 1 + period_of(m_level));
    else pass_cnt++;
  endtask

  task automatic test_score_level();
    bit ok;
    int n, bad, sp0;
    pulse_reset();
    move_btn = 1'b1;
    sp0 = sp_cnt;
    step_tick(1'b0, 9, ok, n);
    run_ticks(5, 1'b0, bad);
    total_cnt++;
    if (!ok || bad != 0) $display("FAIL level0_intervals: got first=%0d bad=%0d, expected 9/0", n, bad); else pass_cnt++;
    total_cnt++;
    if (score !== 12'h002 || level !== 4'd1 || sp_cnt - sp0 != 2)
      $display("FAIL score_level_6_ticks: got score=%h level=%0d pulses=%0d, expected 002/1/2", score, level, sp_cnt - sp0);
    else pass_cnt++;
    step_tick(1'b0, 6, ok, n);
    total_cnt++;
    if (!ok) $display("FAIL level1_period: got %0d cycles, expected 6", n); else pass_cnt++;
    run_ticks(5, 1'b0, bad);
    step_tick(1'b0, 4, ok, n);
    total_cnt++;
    if (!ok || bad != 0 || level !== 4'd2) $display("FAIL level2_period: got %0d cycles level=%0d bad=%0d, expected 4/2/0", n, level, bad);
    else pass_cnt++;
    run_ticks(5, 1'b0, bad);
    step_tick(1'b0, 4, ok, n);
    total_cnt++;
    if (!ok || bad != 0 || level !== 4'd3) $display("FAIL level3_floor: got %0d cycles level=%0d bad=%0d, expected 4/3/0", n, level, bad);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit ok;
    int n, bad;
    pulse_reset();
    move_btn = 1'b1;
    step_tick(1'b0, 9, ok, n);
    run_ticks(8, 1'b0, bad);
    total_cnt++;
    if (!ok || bad != 0 || y_pos !== {10'd16, 10'd18})
      $display("FAIL wrap_pre: got y_pos=%h bad=%0d, expected %h/0", y_pos, bad, {10'd16, 10'd18});
    else pass_cnt++;
    step_tick(1'b0, period_of(m_level), ok, n);
    total_cnt++;
    if (!ok || y_pos !== 20'd0) $display("FAIL wrap_down: got y_pos=%h, expected 00000", y_pos); else pass_cnt++;
    step_tick(1'b1, period_of(m_level), ok, n);
    total_cnt++;
    if (!ok || y_pos !== {10'd16, 10'd18}) $display("FAIL wrap_up: got y_pos=%h, expected %h", y_pos, {10'd16, 10'd18});
    else pass_cnt++;
    run_ticks(3, 1'b1, bad);
    total_cnt++;
    if (bad != 0) $display("FAIL scroll_up_run: got %0d bad intervals, expected 0", bad); else pass_cnt++;
  endtask

  task automatic test_bcd_saturation();
    bit ok;
    int n, bad, sp0;
    pulse_reset();
    move_btn = 1'b1;
    bad = 0;
    step_tick(1'b0, 9, ok, n);
    if (!ok) bad++;
    while (m_score < 100 && bad < 10) begin
      step_tick(1'b0, period_of(m_level), ok, n);
      if (!ok) bad++;
    end
    total_cnt++;
    if (bad != 0 || score !== 12'h100) $display("FAIL bcd_carry_100: got score=%h bad=%0d, expected 100/0", score, bad);
    else pass_cnt++;
    while (m_score < 999 && bad < 10) begin
      step_tick(1'b0, period_of(m_level), ok, n);
      if (!ok) bad++;
    end
    total_cnt++;
    if (bad != 0 || score !== 12'h999) $display("FAIL bcd_reach_999: got score=%h bad=%0d, expected 999/0", score, bad);
    else pass_cnt++;
    sp0 = sp_cnt;
    run_ticks(3 * SCORE_TICKS, 1'b0, bad);
    total_cnt++;
    if (bad != 0 || score !== 12'h999 || sp_cnt != sp0)
      $display("FAIL bcd_saturate: got score=%h pulses=%0d bad=%0d, expected 999/0/0", score, sp_cnt - sp0, bad);
    else pass_cnt++;
    total_cnt++;
    if (level !== 4'(MAX_LEVEL)) $display("FAIL level_saturate: got %0d, expected %0d", level, MAX_LEVEL); else pass_cnt++;
  endtask

  task automatic test_reset_mid_tick();
    bit ok;
    int n;
    // Counter sits at P-1: the next edge would tick, but reset arrives on it.
    repeat (period_of(m_level) - 1) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (tick !== 1'b0 || score_pulse !== 1'b0) $display("FAIL reset_mid_tick_pulse: got tick=%b sp=%b, expected 0/0", tick, score_pulse);
    else pass_cnt++;
    total_cnt++;
    if (y_pos !== '0 || score !== '0 || level !== '0)
      $display("FAIL reset_mid_tick_state: got y_pos=%h score=%h level=%0d, expected all 0", y_pos, score, level);
    else pass_cnt++;
    reset = 1'b0;
    model_reset();
    step_tick(1'b0, 9, ok, n);
    total_cnt++;
    if (!ok) $display("FAIL post_reset_latency: got %0d cycles, expected 9", n); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_pause();
    test_release();
    test_score_level();
    test_wrap();
    test_bcd_saturation();
    test_reset_mid_tick();
    move_btn = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
